fsm_vedacao: RTL and testbench
==============================

# fsm_vedacao

Moore FSM that controls the capping press for the station directly downstream of the filling stage. The master controller commands it with the same level handshake used for filling: `cmd_iniciar` is held high until `tarefa_concluida` is seen, then dropped. The block times the press stroke with a cycle counter and tracks the stock of caps in the dispenser. When the stock is exhausted it holds an alarm and waits for a manual refill.

## Interface
Parameters:
- `CICLOS_VEDACAO`, default 50_000_000: press stroke length in clk cycles (1 s at 50 MHz). Must be ≥1.
- `CAPACIDADE`, default 10: cap stock after reset or refill. Must be ≥1 and fit in `W_ESTOQUE`.
- `W_ESTOQUE`, default 4: width of the stock counter.

Ports:
- `clk` in 1: 50 MHz clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_iniciar` in 1: start command from the master (level).
- `btn_repor` in 1: refill button (level). Acts on its rising edge only.
- `atuador_ativo` out 1: capping press solenoid.
- `tarefa_concluida` out 1: done flag returned to the master.
- `alarme_sem_tampa` out 1: out-of-caps alarm LED.
- `estoque_tampas` out `W_ESTOQUE`: current cap count, for display.

## Operation
- States: `IDLE`, `VEDANDO`, `CONCLUIDO`, `SEM_TAMPA`. Unused state encodings go to `IDLE`.
- `IDLE`:
  - `cmd_iniciar` high and stock > 0: go to `VEDANDO` and clear the timer to 0.
  - `cmd_iniciar` high and stock = 0: go to `SEM_TAMPA`.
- `VEDANDO`:
  - On each edge, if timer = `CICLOS_VEDACAO`−1, go to `CONCLUIDO` and decrement the stock by 1 on that same edge. Otherwise increment the timer.
  - Dropping `cmd_iniciar` here is ignored; the stroke always completes.
- `CONCLUIDO`: go to `IDLE` when `cmd_iniciar` is low.
- `SEM_TAMPA`:
  - `cmd_iniciar` low: go to `IDLE`.
  - `cmd_iniciar` high and stock > 0: go to `VEDANDO` with the timer cleared.
- Outputs are pure Moore decodes of the state register:
  - `atuador_ativo` = (state = `VEDANDO`).
  - `tarefa_concluida` = (state = `CONCLUIDO`).
  - `alarme_sem_tampa` = (state = `SEM_TAMPA`).
- `estoque_tampas` is the stock register itself.
- Refill: an internal edge detector produces a 1-cycle pulse on the rising edge of `btn_repor`. The pulse loads the stock with `CAPACIDADE` in any state.
- Refill pulse and decrement on the same edge: refill wins and the stock becomes `CAPACIDADE`.
- The stock never decrements below 0. A decrement can only occur after entry with stock > 0.
- The timer is `$clog2(CICLOS_VEDACAO)` bits wide (minimum 1) and is not used outside `VEDANDO`.

## Timing
- Reset values:
  - state `IDLE`, timer 0, stock `CAPACIDADE`, edge-detect register 0.
  - Outputs: `atuador_ativo`=0, `tarefa_concluida`=0, `alarme_sem_tampa`=0, `estoque_tampas`=`CAPACIDADE`.
- Start latency: `cmd_iniciar` sampled high at edge N makes `atuador_ativo` high from N through N+`CICLOS_VEDACAO`.
- The stroke lasts exactly `CICLOS_VEDACAO` cycles.
- `tarefa_concluida` rises at edge N+`CICLOS_VEDACAO`; the stock updates on that same edge.
- `tarefa_concluida` falls one edge after `cmd_iniciar` is sampled low.
- If `cmd_iniciar` is already low at the end of the stroke, `CONCLUIDO` lasts exactly 1 cycle.
- Refill pulse: the stock shows `CAPACIDADE` one edge after `btn_repor` is first sampled high.
- A `reset` assertion at any point, including mid-stroke, immediately clears `atuador_ativo` and restores the stock to `CAPACIDADE`. The interrupted bottle is not counted.

## Configuration
- `VEDACAO_SYNC_EN` defined:
  - `cmd_iniciar` and `btn_repor` each pass through a 2-flop synchronizer, reset to 0, before any use.
  - Every input-referenced latency above increases by 2 cycles.
- `VEDACAO_SYNC_EN` undefined: inputs are used directly, assuming the upstream logic is synchronous to `clk`.

## Test plan
All scenarios use `CICLOS_VEDACAO`=4, `CAPACIDADE`=2, `W_ESTOQUE`=4, with the macro undefined unless stated.
- Reset state: assert `reset` → all flags 0, `estoque_tampas`=2.
- Normal cycle: hold `cmd_iniciar` high → `atuador_ativo` high for exactly 4 cycles, then `tarefa_concluida`=1 and stock=1. Drop `cmd_iniciar` → back to `IDLE` one edge later.
- Exhaustion: run 2 full cycles, then raise `cmd_iniciar` → `alarme_sem_tampa`=1 and `atuador_ativo` stays 0. Pulse `btn_repor` → stock=2 and the press starts the following edge.
- Abort attempt: drop `cmd_iniciar` on the 2nd stroke cycle → stroke still lasts 4 cycles, `CONCLUIDO` for 1 cycle, then `IDLE`, stock=1.
- Collision: rising edge of `btn_repor` on the final stroke edge → stock=2, not 1. Holding `btn_repor` high afterwards causes no further reload.
- Mid-stroke reset: assert `reset` on the 3rd stroke cycle → `atuador_ativo` drops immediately, stock=2. With `VEDACAO_SYNC_EN` defined, the start latency becomes 3 edges.

Source files
------------

// File: rtl/fsm_vedacao.sv
`timescale 1ns/1ps
// fsm_vedacao: Moore controller for the capping press downstream of filling.
// The master holds cmd_iniciar high until tarefa_concluida is seen. A stroke
// runs for CICLOS_VEDACAO cycles and consumes one cap from the dispenser
// stock. An empty dispenser raises an alarm until a refill (rising edge of
// btn_repor) reloads the stock to CAPACIDADE.
//
// Ports:
//   clk              - clock (50 MHz)
//   reset            - asynchronous, active-high reset
//   cmd_iniciar      - start command from master (level)
//   btn_repor        - refill button (level, acts on rising edge)
//   atuador_ativo    - press solenoid, high while stroking
//   tarefa_concluida - done flag back to the master
//   alarme_sem_tampa - out-of-caps alarm
//   estoque_tampas   - current cap stock
//
// Build option: define VEDACAO_SYNC_EN to pass cmd_iniciar and btn_repor
// through 2-flop synchronizers (adds 2 cycles of input latency).
module fsm_vedacao #(
  parameter int unsigned CICLOS_VEDACAO = 50_000_000,
  parameter int unsigned CAPACIDADE     = 10,
  parameter int unsigned W_ESTOQUE      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_iniciar,
  input  logic                 btn_repor,
  output logic                 atuador_ativo,
  output logic                 tarefa_concluida,
  output logic                 alarme_sem_tampa,
  output logic [W_ESTOQUE-1:0] estoque_tampas
);

  localparam int unsigned WTimer = (CICLOS_VEDACAO > 1) ? $clog2(CICLOS_VEDACAO) : 1;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StVedando   = 2'd1;
  localparam logic [1:0] StConcluido = 2'd2;
  localparam logic [1:0] StSemTampa  = 2'd3;

  localparam logic [WTimer-1:0]    TimerLast  = WTimer'(CICLOS_VEDACAO - 1);
  localparam logic [W_ESTOQUE-1:0] Capacidade = W_ESTOQUE'(CAPACIDADE);

  logic cmd_s;
  logic btn_s;

`ifdef VEDACAO_SYNC_EN
  logic [1:0] cmd_sync_q;
  logic [1:0] btn_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_sync_q <= 2'b00;
      btn_sync_q <= 2'b00;
    end else begin
      cmd_sync_q <= {cmd_sync_q[0], cmd_iniciar};
      btn_sync_q <= {btn_sync_q[0], btn_repor};
    end
  end

  assign cmd_s = cmd_sync_q[1];
  assign btn_s = btn_sync_q[1];
`else
  assign cmd_s = cmd_iniciar;
  assign btn_s = btn_repor;
`endif

  logic [1:0]           state_q, state_d;
  logic [WTimer-1:0]    timer_q, timer_d;
  logic [W_ESTOQUE-1:0] stock_q, stock_d;
  logic                 btn_prev_q;
  logic                 refill;
  logic                 stock_zero;
  logic                 dec;

  // Single-cycle pulse on the rising edge of the (possibly synchronized) button.
  assign refill     = btn_s & ~btn_prev_q;
  assign stock_zero = (stock_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_s) begin
          if (!stock_zero) begin
            state_d = StVedando;
            timer_d = '0;
          end else begin
            state_d = StSemTampa;
          end
        end
      end
      StVedando: begin
        // cmd_iniciar is deliberately ignored: the stroke always completes.
        if (timer_q == TimerLast) begin
          state_d = StConcluido;
          dec     = 1'b1;
        end else begin
          timer_d = timer_q + WTimer'(1);
        end
      end
      StConcluido: begin
        if (!cmd_s) state_d = StIdle;
      end
      StSemTampa: begin
        if (!cmd_s) begin
          state_d = StIdle;
        end else if (!stock_zero) begin
          state_d = StVedando;
          timer_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Refill takes priority over a same-edge decrement.
  always_comb begin
    stock_d = stock_q;
    if (refill) begin
      stock_d = Capacidade;
    end else if (dec && !stock_zero) begin
      stock_d = stock_q - W_ESTOQUE'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      stock_q    <= Capacidade;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      stock_q    <= stock_d;
      btn_prev_q <= btn_s;
    end
  end

  assign atuador_ativo    = (state_q == StVedando);
  assign tarefa_concluida = (state_q == StConcluido);
  assign alarme_sem_tampa = (state_q == StSemTampa);
  assign estoque_tampas   = stock_q;

endmodule

// File: tb/tb_fsm_vedacao.sv
`timescale 1ns/1ps
module tb_fsm_vedacao;

  localparam int unsigned Ciclos = 4;
  localparam int unsigned Cap    = 2;
  localparam int unsigned WEst   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_iniciar;
  logic            btn_repor;
  logic            atuador_ativo;
  logic            tarefa_concluida;
  logic            alarme_sem_tampa;
  logic [WEst-1:0] estoque_tampas;

  int checks = 0;
  int errors = 0;

  // Reference model: what the press is doing, described by the operating rules.
  int m_stock;
  int m_left;      // stroke cycles still to run while pressing
  bit m_press;
  bit m_done;
  bit m_alarm;
  bit m_btn_prev;

  fsm_vedacao #(
    .CICLOS_VEDACAO(Ciclos),
    .CAPACIDADE    (Cap),
    .W_ESTOQUE     (WEst)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_iniciar     (cmd_iniciar),
    .btn_repor       (btn_repor),
    .atuador_ativo   (atuador_ativo),
    .tarefa_concluida(tarefa_concluida),
    .alarme_sem_tampa(alarme_sem_tampa),
    .estoque_tampas  (estoque_tampas)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_stock    = Cap;
    m_left     = 0;
    m_press    = 1'b0;
    m_done     = 1'b0;
    m_alarm    = 1'b0;
    m_btn_prev = 1'b0;
  endtask

  task automatic model_edge(input bit cmd, input bit btn);
    bit refill;
    refill     = btn && !m_btn_prev;
    m_btn_prev = btn;
    if (m_press) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_press = 1'b0;
        m_done  = 1'b1;
        if (m_stock > 0) m_stock = m_stock - 1;
      end
    end else if (m_done) begin
      if (!cmd) m_done = 1'b0;
    end else if (m_alarm) begin
      if (!cmd) begin
        m_alarm = 1'b0;
      end else if (m_stock > 0) begin
        m_alarm = 1'b0;
        m_press = 1'b1;
        m_left  = Ciclos;
      end
    end else if (cmd) begin
      if (m_stock > 0) begin
        m_press = 1'b1;
        m_left  = Ciclos;
      end else begin
        m_alarm = 1'b1;
      end
    end
    if (refill) m_stock = Cap;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".atuador"}, {31'd0, atuador_ativo}, {31'd0, m_press});
    chk({tag, ".concluida"}, {31'd0, tarefa_concluida}, {31'd0, m_done});
    chk({tag, ".alarme"}, {31'd0, alarme_sem_tampa}, {31'd0, m_alarm});
    chk({tag, ".estoque"}, {28'd0, estoque_tampas}, m_stock);
  endtask

  // Called at a negedge: drive inputs, let one edge pass, check at next negedge.
  task automatic step(input string tag, input bit cmd, input bit btn);
    cmd_iniciar = cmd;
    btn_repor   = btn;
    @(posedge clk);
    model_edge(cmd, btn);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    cmd_iniciar = 1'b0;
    btn_repor   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    step("idle", 1'b0, 1'b0);

    // Normal cycle, also counting stroke length directly.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step("normal", 1'b1, 1'b0);
      if (atuador_ativo) n++;
    end
    chk("stroke_len", n, Ciclos);
    chk("done_after_stroke", {31'd0, tarefa_concluida}, 32'd1);
    chk("stock_after_stroke", {28'd0, estoque_tampas}, 32'd1);
    step("drop", 1'b0, 1'b0);
    step("drop", 1'b0, 1'b0);

    // Second cycle empties the dispenser, then exhaustion and refill.
    for (int i = 0; i < 6; i++) step("second", 1'b1, 1'b0);
    step("second_drop", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("empty", 1'b1, 1'b0);
    chk("alarm_on", {31'd0, alarme_sem_tampa}, 32'd1);
    step("refill", 1'b1, 1'b1);
    step("restart", 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("refilled_run", 1'b1, 1'b0);
    step("refilled_drop", 1'b0, 1'b0);

    // Refill, then abort attempt on the 2nd stroke cycle.
    step("refill2", 1'b0, 1'b1);
    step("refill2", 1'b0, 1'b0);
    step("abort_start", 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("abort", 1'b0, 1'b0);

    // Collision: button rises on the final stroke edge, then held.
    step("coll_start", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("coll", 1'b1, 1'b0);
    step("coll_edge", 1'b1, 1'b1);
    chk("coll_stock", {28'd0, estoque_tampas}, Cap);
    step("coll_hold", 1'b1, 1'b1);
    step("coll_hold", 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step("coll_hold_run", 1'b1, 1'b1);
    step("coll_rel", 1'b0, 1'b0);

    // Mid-stroke asynchronous reset.
    step("rst_start", 1'b1, 1'b0);
    step("rst_run", 1'b1, 1'b0);
    step("rst_run", 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    cmd_iniciar = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_all("rst_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 4) != 0, ($urandom % 10) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
